phase_timer: RTL
================

Name: phase_timer

Overview:
- Parametrised successor to the single-channel state-duration timer used by the traffic-light FSM.
- Counts a programmable number of seconds from a CLK_HZ clock via an internal prescaler.
- Adds:
  - explicit start/load
  - pause (enable low) without losing progress
  - abort
  - reload while running
  - a live remaining-seconds readout for displays
- Emits a one-cycle finished pulse that the light-sequencing FSM uses as its "advance state" strobe.

Parameters:
- CLK_HZ, 10000, input clock frequency; prescaler terminal count is CLK_HZ-1.
- SEC_W, 16, width of the seconds operand and the remaining counter.
- PRE_W, $clog2(CLK_HZ), prescaler width (derived, not overridden).

Ports:
- CLK  in  1  system clock (10 kHz in the current board build).
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  count enable; low = pause (prescaler and remaining frozen).
- start  in  1  load secondsToCount and begin timing (single-cycle strobe).
- abort  in  1  cancel the current interval without asserting finished.
- secondsToCount  in  SEC_W  interval length in seconds, sampled only when start=1.
- busy  out  1  high while an interval is loaded and not yet finished or aborted.
- finished  out  1  one-cycle pulse at interval expiry.
- tick  out  1  one-cycle pulse on every prescaler wrap while busy (1 Hz at CLK_HZ).
- remaining  out  SEC_W  seconds left, including the partial second in progress.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; prescaler=0.
  - remaining=0, busy=0, finished=0, tick=0, all immediately.
  - Reset mid-interval discards the interval; no finished pulse.
- State machine has three states: IDLE, RUN, PAUSE.
  - PAUSE is RUN with enable=0.
  - The busy output is high in RUN and PAUSE.
- start=1 at edge E0, with N=secondsToCount, in any state:
  - N>0: remaining<=N, prescaler<=0, busy<=1, state<=RUN. The in-progress interval is discarded (restart).
  - N=0: finished<=1 at E0, busy<=0, remaining<=0, state<=IDLE.
- In RUN with enable=1, each edge increments the prescaler.
- When prescaler==CLK_HZ-1 at an edge (the wrap edge):
  - prescaler<=0, tick<=1, remaining<=remaining-1.
  - If remaining==1 before the wrap: finished<=1, busy<=0, state<=IDLE.
- Latency: finished is high for exactly the cycle after edge E0+N*CLK_HZ, counting enabled edges only. Pause cycles extend the interval one-for-one.
- finished and tick are high for exactly one cycle. On the final wrap both are high together.
- enable=0: prescaler, remaining and state hold; tick=0. The start and abort inputs are still honoured.
- abort=1 (and start=0): state<=IDLE, busy<=0, prescaler<=0, remaining<=0, finished stays 0.
- start and abort on the same edge: start wins (reload).
- start on the same edge as the final wrap: start wins and finished is not pulsed.
- In IDLE: prescaler is held at 0, tick=0, and enable is ignored.
- Arithmetic:
  - remaining never underflows; decrement occurs only when remaining is at least 1.
  - The prescaler compares against the constant CLK_HZ-1; there is no wrap-around beyond it.
- secondsToCount changes while busy have no effect until the next start.

Decomposition:
- Package phase_timer_pkg:
  - state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2.
  - default CLK_HZ constant, shared with other timing blocks.
- Sub-module sec_prescaler (params CLK_HZ):
  - inputs: CLK, reset, clear, run.
  - output: wrap pulse.
  - Instantiated once; phase_timer holds the FSM and the remaining counter.

Test Plan (CLK_HZ=4 for simulation):
- Case 1, basic run: reset, then start with secondsToCount=3, enable=1 throughout.
  - Expected: busy high the cycle after the start edge.
  - Expected: tick pulses at enabled edges 4, 8 and 12 after start.
  - Expected: remaining steps 3→2→1→0.
  - Expected: finished high exactly 1 cycle, after edge 12; busy low in the same cycle.
- Case 2, pause: start secondsToCount=2, drop enable for 5 cycles mid-second.
  - Expected: finished after edge 13 instead of 8.
  - Expected: remaining and prescaler frozen during the pause, and no tick while paused.
- Case 3, zero length: start secondsToCount=0.
  - Expected: finished high the cycle after start; busy never asserts; no tick.
- Case 4, abort: start secondsToCount=5, assert abort after 6 cycles.
  - Expected: busy=0 and remaining=0 next cycle, and finished never pulses.
  - Also: start and abort together reloads the interval.
- Case 5, restart and async reset:
  - Start 4, then after 10 cycles start 2. Expected: finished 8 cycles after the second start.
  - Separately, assert reset asynchronously between edges mid-run. Expected: all outputs 0 immediately, with no finished pulse.
- Case 6, final-wrap collision: start on the exact final-wrap edge.
  - Expected: finished stays 0 and remaining reloads to the new value.

Source files
------------

// File: rtl/phase_timer_pkg.sv
// Shared definitions for the phase timer and other second-based timing blocks.
package phase_timer_pkg;

  localparam int unsigned DefaultClkHz = 10000;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } phase_state_e;

endpackage

// File: rtl/sec_prescaler.sv
// Divides the system clock down to a one-cycle wrap strobe every CLK_HZ enabled cycles.
module sec_prescaler #(
  parameter int unsigned CLK_HZ = phase_timer_pkg::DefaultClkHz
) (
  input  logic CLK,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic wrap
);

  localparam int unsigned PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] TermCount = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0] count_q, count_d;
  logic             at_term;

  assign at_term = (count_q == TermCount);
  assign wrap    = run && at_term;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = at_term ? '0 : count_q + PRE_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/phase_timer.sv
// Programmable seconds timer with pause, abort and reload; pulses finished at expiry.
module phase_timer
  import phase_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ = DefaultClkHz,
  parameter int unsigned SEC_W  = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             abort,
  input  logic [SEC_W-1:0] secondsToCount,
  output logic             busy,
  output logic             finished,
  output logic             tick,
  output logic [SEC_W-1:0] remaining
);

  phase_state_e     state_q, state_d;
  logic [SEC_W-1:0] remaining_q, remaining_d;
  logic             finished_q, finished_d;
  logic             tick_q, tick_d;
  logic             active;
  logic             pre_clear;
  logic             pre_run;
  logic             wrap;

  assign active    = (state_q != StIdle);
  assign pre_clear = start || abort;
  assign pre_run   = active && enable;

  sec_prescaler #(
    .CLK_HZ(CLK_HZ)
  ) u_prescaler (
    .CLK  (CLK),
    .reset(reset),
    .clear(pre_clear),
    .run  (pre_run),
    .wrap (wrap)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      finished_q  <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      finished_q  <= finished_d;
      tick_q      <= tick_d;
    end
  end

  // Priority: start (reload) over abort over normal counting.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    finished_d  = 1'b0;
    tick_d      = 1'b0;
    if (start) begin
      if (secondsToCount != '0) begin
        remaining_d = secondsToCount;
        state_d     = StRun;
      end else begin
        remaining_d = '0;
        finished_d  = 1'b1;
        state_d     = StIdle;
      end
    end else if (abort) begin
      remaining_d = '0;
      state_d     = StIdle;
    end else if (active) begin
      if (enable) begin
        state_d = StRun;
        if (wrap) begin
          tick_d = 1'b1;
          if (remaining_q != '0) begin
            remaining_d = remaining_q - SEC_W'(1);
          end
          if (remaining_q <= SEC_W'(1)) begin
            finished_d = 1'b1;
            state_d    = StIdle;
          end
        end
      end else begin
        state_d = StPause;
      end
    end
  end

  always_comb begin
    busy      = active;
    finished  = finished_q;
    tick      = tick_q;
    remaining = remaining_q;
  end

endmodule
